uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of AXIS requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, byte width of each stream.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, mid-packet stall limit in i_clk cycles (>=2).
REQ-004 SHALL have port i_clk  input  1  single clock domain; all logic rising-edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_s_axis_tvalid  input  N_REQ  per-requester valid.
REQ-007 SHALL have port i_s_axis_tdata  input  N_REQ*DATA_W  packed data; requester k at bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port i_s_axis_tlast  input  N_REQ  per-requester end of message.
REQ-009 SHALL have port o_s_axis_tready  output  N_REQ  per-requester ready.
REQ-010 SHALL have port o_m_axis_tvalid  output  1  valid toward the uart_tx_wrap slave port.
REQ-011 SHALL have port o_m_axis_tdata  output  DATA_W  data toward the uart_tx_wrap slave port.
REQ-012 SHALL have port o_m_axis_tlast  output  1  end of message, forwarded.
REQ-013 SHALL have port i_m_axis_tready  input  1  ready from the uart_tx_wrap slave port.
REQ-014 SHALL have port o_grant  output  N_REQ  one-hot current owner; all zero when idle.
REQ-015 SHALL have port o_busy  output  1  high while a grant is held.
REQ-016 SHALL have port o_timeout  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-017 SHALL implement FSM with states IDLE and LOCKED, held in registers.
REQ-018 SHALL, in IDLE with any i_s_axis_tvalid high, register a grant to the first valid requester searching upward from (rr_ptr+1) mod N_REQ with wrap, and enter LOCKED on the next edge.
REQ-019 SHALL take exactly one cycle from first tvalid in IDLE to o_grant assertion; no beat transfers in IDLE.
REQ-020 SHALL, in LOCKED, route the granted requester combinationally: o_m_axis_tvalid/tdata/tlast = granted inputs, o_s_axis_tready[g] = i_m_axis_tready.
REQ-021 SHALL hold o_s_axis_tready low for every non-granted requester and for all requesters in IDLE.
REQ-022 SHALL drive o_m_axis_tvalid low in IDLE and o_m_axis_tdata/tlast to zero whenever o_m_axis_tvalid is low.
REQ-023 SHALL, on an accepted beat (o_m_axis_tvalid and i_m_axis_tready) with tlast high, return to IDLE next edge and set rr_ptr to the granted index.
REQ-024 SHALL never switch owner between beats of one message (tlast not yet accepted).
REQ-025 SHALL count cycles in LOCKED where the granted tvalid is low; counter clears on every accepted beat and on entering LOCKED.
REQ-026 SHALL not count cycles where granted tvalid is high but i_m_axis_tready is low (backpressure is not a stall).
REQ-027 SHALL, when the stall counter reaches TIMEOUT_CYCLES, return to IDLE, set rr_ptr to the granted index, and pulse o_timeout for one cycle.
REQ-028 SHALL size the stall counter to $clog2(TIMEOUT_CYCLES+1) bits and saturate, never wrap.
REQ-029 SHALL, when only one requester is valid, grant it regardless of rr_ptr.
REQ-030 SHALL ignore a requester dropping tvalid in IDLE before grant; the grant is re-evaluated only from IDLE.

Reset
REQ-031 SHALL, on i_rst high at a clock edge, enter IDLE, set rr_ptr to N_REQ-1 (so requester 0 wins first), clear stall counter, o_grant, o_busy, o_timeout.
REQ-032 SHALL abandon any message in progress on reset; no partial-message recovery.
REQ-033 SHALL hold all outputs at reset values while i_rst is high.

Structure
REQ-034 SHALL place the state enum (IDLE, LOCKED) in shared package uart_pkg alongside the default DATA_W constant.
REQ-035 SHALL instantiate one sub-module rr_pick: combinational round-robin priority picker (request vector, pointer -> one-hot grant, any).
REQ-036 SHALL connect directly to uart_tx_wrap with no buffering in this block.

Verification
REQ-037 SHALL cover: reset, req0 and req2 valid simultaneously -> req0 granted cycle 2, its 3-byte message 0x41,0x42,0x43 sent, then req2 granted.
REQ-038 SHALL cover: all 4 requesters continuously valid with 1-byte messages -> grant order 0,1,2,3,0.
REQ-039 SHALL cover: req1 mid-message drops tvalid for TIMEOUT_CYCLES=16 -> o_timeout pulses once after 16 stall cycles, o_grant returns to 0, req2 then granted.
REQ-040 SHALL cover: i_m_axis_tready low 50 cycles mid-message -> no timeout, no data loss, byte order preserved.
REQ-041 SHALL cover: i_rst asserted during LOCKED -> next edge o_grant=0, o_busy=0, o_m_axis_tvalid=0; after release req0 wins.
REQ-042 SHALL check by assertion: o_grant one-hot or zero, at most one o_s_axis_tready high, no owner change before tlast accepted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter FSM states and
// the default stream byte width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker. The requester just after ptr
// has highest priority, wrapping around; the result is one-hot (or zero).
module rr_pick
  import uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any
);

  logic [PW:0]    sh;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   rgnt;
  logic [2*N-1:0] dgnt;

  // Rotate so that requester ptr+1 lands at bit 0, take the lowest set bit,
  // then rotate the single grant bit back to its requester position.
  assign sh   = {1'b0, ptr} + 1'b1;
  assign dbl  = {req, req} >> sh;
  assign rot  = dbl[N-1:0];
  assign rgnt = rot & (~rot + 1'b1);
  assign dgnt = {rgnt, rgnt} << sh;
  assign gnt  = dgnt[2*N-1:N];
  assign any  = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter merging N_REQ AXI-Stream byte sources
// into the single uart_tx_wrap slave port. A grant is held until the owner's
// tlast beat is accepted or the owner stalls for TIMEOUT_CYCLES cycles.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int DATA_W         = UART_DATA_W,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_s_axis_tvalid,
  input  logic [N_REQ*DATA_W-1:0] i_s_axis_tdata,
  input  logic [N_REQ-1:0]        i_s_axis_tlast,
  output logic [N_REQ-1:0]        o_s_axis_tready,
  output logic                    o_m_axis_tvalid,
  output logic [DATA_W-1:0]       o_m_axis_tdata,
  output logic                    o_m_axis_tlast,
  input  logic                    i_m_axis_tready,
  output logic [N_REQ-1:0]        o_grant,
  output logic                    o_busy,
  output logic                    o_timeout
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT_CYCLES);

  arb_state_t        state;
  logic [N_REQ-1:0]  grant;
  logic [PW-1:0]     rr_ptr;
  logic [CW-1:0]     stall_cnt;
  logic [CW-1:0]     stall_nxt;
  logic              timeout;

  logic [N_REQ-1:0]  pick;
  logic              pick_any;

  logic [PW-1:0]     gidx;
  logic              g_valid;
  logic [DATA_W-1:0] g_data;
  logic              g_last;
  logic              live;
  logic              beat;

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req (i_s_axis_tvalid),
    .ptr (rr_ptr),
    .gnt (pick),
    .any (pick_any)
  );

  // Select the granted requester's stream and its index from the one-hot grant.
  always_comb begin
    gidx    = '0;
    g_valid = 1'b0;
    g_data  = '0;
    g_last  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        gidx    = PW'(k);
        g_valid = i_s_axis_tvalid[k];
        g_data  = i_s_axis_tdata[k*DATA_W +: DATA_W];
        g_last  = i_s_axis_tlast[k];
      end
    end
  end

  // Routing is live only while locked; reset forces every output quiet
  // immediately, even before the first reset edge has been seen.
  assign live            = (state == LOCKED) & ~i_rst;
  assign o_m_axis_tvalid = live & g_valid;
  assign o_m_axis_tdata  = o_m_axis_tvalid ? g_data : '0;
  assign o_m_axis_tlast  = o_m_axis_tvalid & g_last;
  assign o_s_axis_tready = grant & {N_REQ{live & i_m_axis_tready}};
  assign o_grant         = i_rst ? '0 : grant;
  assign o_busy          = live;
  assign o_timeout       = timeout & ~i_rst;

  assign beat      = o_m_axis_tvalid & i_m_axis_tready;
  assign stall_nxt = (stall_cnt == T_MAX) ? T_MAX : stall_cnt + 1'b1;

  // Arbiter FSM: grant from IDLE, hold the owner until tlast or stall timeout.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= PW'(N_REQ - 1);
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant     <= pick;
            state     <= LOCKED;
            stall_cnt <= '0;
          end
        end
        LOCKED: begin
          if (beat && g_last) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= gidx;
            stall_cnt <= '0;
          end else if (beat) begin
            stall_cnt <= '0;
          end else if (!g_valid) begin
            // Only a missing source beat counts; sink backpressure does not.
            stall_cnt <= stall_nxt;
            if (stall_nxt == T_MAX) begin
              state   <= IDLE;
              grant   <= '0;
              rr_ptr  <= gidx;
              timeout <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queue-based sources, a
// message-level round-robin reference model, and directed/random scenarios.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic [N-1:0]    req_last  = '0;
  logic [N-1:0]    req_ready;
  logic            m_valid;
  logic [DW-1:0]   m_data;
  logic            m_last;
  logic            m_ready = 1'b1;
  logic [N-1:0]    gnt;
  logic            busy;
  logic            tmo;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_s_axis_tvalid (req_valid),
    .i_s_axis_tdata  (req_data),
    .i_s_axis_tlast  (req_last),
    .o_s_axis_tready (req_ready),
    .o_m_axis_tvalid (m_valid),
    .o_m_axis_tdata  (m_data),
    .o_m_axis_tlast  (m_last),
    .i_m_axis_tready (m_ready),
    .o_grant         (gnt),
    .o_busy          (busy),
    .o_timeout       (tmo)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Source beats per requester: {last, data}.
  logic [8:0]  sq [N][$];
  // Output log / expectation entries: {requester[3:0], last, data}.
  logic [12:0] out_q[$];
  logic [12:0] exp_q[$];
  int          gnt_q[$];
  int          exp_gnt[$];

  logic [N-1:0] src_en  = '1;
  logic [N-1:0] mid     = '0;
  bit           gap_en  = 1'b0;
  bit           rdy_rand = 1'b0;
  logic         rdy_fix = 1'b1;
  int           n_to    = 0;
  logic [N-1:0] last_g  = '0;
  int           mdl_ptr = N - 1;

  logic [N-1:0]  ob_gnt = '0;
  logic [N-1:0]  ob_rdy = '0;
  logic          ob_busy, ob_tmo, ob_mv, ob_ml;
  logic [DW-1:0] ob_md;

  function automatic int oh_idx(input logic [N-1:0] v);
    oh_idx = 15;
    for (int k = N - 1; k >= 0; k--) if (v[k]) oh_idx = k;
  endfunction

  function automatic bit all_empty();
    all_empty = 1'b1;
    for (int k = 0; k < N; k++) if (sq[k].size() != 0) all_empty = 1'b0;
  endfunction

  // One clock of stimulus: drive sources and sink, sample at negedge, pop
  // accepted beats after the edge.
  task automatic cyc();
    logic [N-1:0] acc;
    for (int k = 0; k < N; k++) begin
      if (src_en[k] && sq[k].size() > 0 && !(gap_en && mid[k] && $urandom_range(3) == 0)) begin
        req_valid[k]          = 1'b1;
        req_data[k*DW +: DW]  = sq[k][0][7:0];
        req_last[k]           = sq[k][0][8];
      end else begin
        req_valid[k]          = 1'b0;
        req_data[k*DW +: DW]  = '0;
        req_last[k]           = 1'b0;
      end
    end
    m_ready = rdy_rand ? ($urandom_range(9) < 7) : rdy_fix;
    @(negedge clk);
    ob_gnt = gnt; ob_rdy = req_ready; ob_busy = busy; ob_tmo = tmo;
    ob_mv = m_valid; ob_md = m_data; ob_ml = m_last;
    acc = req_valid & req_ready;
    if (ob_mv && m_ready) out_q.push_back({4'(oh_idx(ob_gnt)), ob_ml, ob_md});
    if (ob_gnt != last_g && ob_gnt != '0) gnt_q.push_back(oh_idx(ob_gnt));
    last_g = ob_gnt;
    if (ob_tmo) n_to++;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (acc[k] && sq[k].size() > 0) begin
        mid[k] = !sq[k][0][8];
        void'(sq[k].pop_front());
      end
    end
  endtask

  task automatic clear_logs();
    out_q.delete(); gnt_q.delete(); exp_q.delete(); exp_gnt.delete();
    n_to = 0;
  endtask

  task automatic reset_dut();
    for (int k = 0; k < N; k++) sq[k].delete();
    src_en = '1; mid = '0; gap_en = 1'b0; rdy_rand = 1'b0; rdy_fix = 1'b1;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    clear_logs();
    last_g = '0;
    mdl_ptr = N - 1;
  endtask

  task automatic push_msg(input int k, input int len);
    for (int i = 0; i < len; i++) sq[k].push_back({(i == len - 1), 8'($urandom)});
  endtask

  // Reference: whenever the arbiter is free, the next owner is the first
  // requester with a pending message after the previous owner; it then sends
  // its whole message.
  task automatic predict();
    logic [8:0] cq [N][$];
    int o;
    bit done;
    for (int k = 0; k < N; k++) cq[k] = sq[k];
    exp_q.delete(); exp_gnt.delete();
    forever begin
      o = -1;
      for (int i = 1; i <= N; i++)
        if (o < 0 && cq[(mdl_ptr + i) % N].size() > 0) o = (mdl_ptr + i) % N;
      if (o < 0) break;
      exp_gnt.push_back(o);
      done = 1'b0;
      while (!done && cq[o].size() > 0) begin
        exp_q.push_back({4'(o), cq[o][0]});
        done = cq[o][0][8];
        void'(cq[o].pop_front());
      end
      mdl_ptr = o;
    end
  endtask

  task automatic drain(input int budget, output bit ok);
    int c = 0;
    while (c < budget && !(all_empty() && ob_gnt == '0)) begin
      cyc();
      c++;
    end
    ok = all_empty() && ob_gnt == '0;
  endtask

  task automatic test_reset();
    reset_dut();
    for (int k = 0; k < N; k++) sq[k].push_back({1'b1, 8'(8'h10 + k)});
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_chk++; if (ob_gnt !== '0)   begin n_fail++; $display("FAIL reset_grant got %b want 0", ob_gnt); end
      n_chk++; if (ob_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", ob_busy); end
      n_chk++; if (ob_tmo !== 1'b0)  begin n_fail++; $display("FAIL reset_timeout got %b want 0", ob_tmo); end
      n_chk++; if (ob_mv !== 1'b0 || ob_rdy !== '0) begin
        n_fail++; $display("FAIL reset_handshake got mv=%b rdy=%b want 0/0", ob_mv, ob_rdy);
      end
    end
    rst = 1'b0;
    cyc();
    n_chk++; if (ob_gnt !== '0 || ob_mv !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_cycle got gnt=%b mv=%b want 0/0", ob_gnt, ob_mv);
    end
    cyc();
    n_chk++; if (ob_gnt !== 4'b0001 || ob_busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_first_win got gnt=%b busy=%b want 0001/1", ob_gnt, ob_busy);
    end
  endtask

  task automatic test_basic();
    bit ok;
    reset_dut();
    sq[0].push_back({1'b0, 8'h41}); sq[0].push_back({1'b0, 8'h42}); sq[0].push_back({1'b1, 8'h43});
    push_msg(2, 2);
    predict();
    cyc();
    n_chk++; if (ob_gnt !== '0 || ob_mv !== 1'b0) begin
      n_fail++; $display("FAIL basic_cycle1 got gnt=%b mv=%b want 0/0", ob_gnt, ob_mv);
    end
    cyc();
    n_chk++; if (ob_gnt !== 4'b0001 || ob_mv !== 1'b1 || ob_md !== 8'h41) begin
      n_fail++; $display("FAIL basic_cycle2 got gnt=%b mv=%b d=%h want 0001/1/41", ob_gnt, ob_mv, ob_md);
    end
    drain(200, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL basic_drain got not idle want idle within 200 cycles"); end
    n_chk++; if (out_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL basic_len got %0d want %0d", out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_chk++; if (out_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL basic_beat%0d got %h want %h", i, out_q[i], exp_q[i]);
      end
    end
    n_chk++; if (gnt_q.size() != 2 || gnt_q[0] != 0 || gnt_q[1] != 2) begin
      n_fail++; $display("FAIL basic_order got %p want '{0,2}", gnt_q);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int want[5] = '{0, 1, 2, 3, 0};
    reset_dut();
    for (int k = 0; k < N; k++) begin push_msg(k, 1); push_msg(k, 1); end
    predict();
    drain(200, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rr_drain got not idle want idle within 200 cycles"); end
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (i >= gnt_q.size() || gnt_q[i] != want[i]) begin
        n_fail++; $display("FAIL rr_grant%0d got %p want %0d", i, gnt_q, want[i]);
      end
    end
    n_chk++; if (out_q != exp_q) begin
      n_fail++; $display("FAIL rr_stream got %p want %p", out_q, exp_q);
    end
  endtask

  task automatic test_timeout();
    bit ok, seen;
    int stall, c;
    logic [7:0] a0, b0, b1;
    reset_dut();
    a0 = 8'($urandom); b0 = 8'($urandom); b1 = 8'($urandom);
    sq[1].push_back({1'b0, a0}); sq[1].push_back({1'b0, 8'hA1}); sq[1].push_back({1'b1, 8'hA2});
    sq[2].push_back({1'b0, b0}); sq[2].push_back({1'b1, b1});
    c = 0;
    while (out_q.size() < 1 && c < 10) begin cyc(); c++; end
    n_chk++; if (out_q.size() < 1 || out_q[0] !== {4'd1, 1'b0, a0}) begin
      n_fail++; $display("FAIL to_first_beat got %p want req1 %h", out_q, a0);
    end
    src_en[1] = 1'b0;
    stall = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      if (ob_tmo) seen = 1'b1;
      else if (ob_gnt == 4'b0010 && !ob_mv) stall++;
    end
    n_chk++; if (!seen) begin n_fail++; $display("FAIL to_pulse got none want pulse within 40 cycles"); end
    n_chk++; if (stall != TO) begin n_fail++; $display("FAIL to_stall_cycles got %0d want %0d", stall, TO); end
    n_chk++; if (ob_gnt !== '0) begin n_fail++; $display("FAIL to_grant_drop got %b want 0", ob_gnt); end
    cyc();
    n_chk++; if (ob_tmo !== 1'b0) begin n_fail++; $display("FAIL to_single_pulse got %b want 0", ob_tmo); end
    n_chk++; if (ob_gnt !== 4'b0100) begin n_fail++; $display("FAIL to_next_owner got %b want 0100", ob_gnt); end
    sq[1].delete();
    drain(100, ok);
    exp_q.delete();
    exp_q.push_back({4'd1, 1'b0, a0}); exp_q.push_back({4'd2, 1'b0, b0}); exp_q.push_back({4'd2, 1'b1, b1});
    n_chk++; if (!ok || out_q != exp_q) begin
      n_fail++; $display("FAIL to_stream got %p want %p", out_q, exp_q);
    end
    n_chk++; if (n_to != 1) begin n_fail++; $display("FAIL to_count got %0d want 1", n_to); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int c, bad;
    logic [7:0] held;
    reset_dut();
    push_msg(0, 6);
    push_msg(3, 2);
    held = sq[0][2][7:0];
    predict();
    c = 0;
    while (out_q.size() < 2 && c < 10) begin cyc(); c++; end
    rdy_fix = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (ob_gnt !== 4'b0001 || ob_mv !== 1'b1 || ob_md !== held || ob_tmo !== 1'b0) bad++;
    end
    n_chk++; if (bad != 0) begin
      n_fail++; $display("FAIL bp_hold got %0d bad cycles want 0 (last gnt=%b d=%h)", bad, ob_gnt, ob_md);
    end
    rdy_fix = 1'b1;
    drain(100, ok);
    n_chk++; if (!ok || out_q != exp_q) begin
      n_fail++; $display("FAIL bp_stream got %p want %p", out_q, exp_q);
    end
    n_chk++; if (n_to != 0) begin n_fail++; $display("FAIL bp_no_timeout got %0d want 0", n_to); end
    n_chk++; if (gnt_q != exp_gnt) begin n_fail++; $display("FAIL bp_order got %p want %p", gnt_q, exp_gnt); end
  endtask

  task automatic test_reset_locked();
    bit ok;
    int c;
    reset_dut();
    push_msg(1, 1);
    push_msg(2, 5);
    c = 0;
    while (out_q.size() < 2 && c < 20) begin cyc(); c++; end
    n_chk++; if (ob_gnt !== 4'b0100) begin n_fail++; $display("FAIL rl_pre_owner got %b want 0100", ob_gnt); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < N; k++) sq[k].delete();
    mid = '0;
    clear_logs();
    mdl_ptr = N - 1;
    push_msg(0, 1);
    push_msg(2, 1);
    predict();
    cyc();
    n_chk++; if (ob_gnt !== '0 || ob_busy !== 1'b0 || ob_mv !== 1'b0) begin
      n_fail++; $display("FAIL rl_after_reset got gnt=%b busy=%b mv=%b want 0/0/0", ob_gnt, ob_busy, ob_mv);
    end
    cyc();
    n_chk++; if (ob_gnt !== 4'b0001) begin n_fail++; $display("FAIL rl_req0_wins got %b want 0001", ob_gnt); end
    drain(100, ok);
    n_chk++; if (!ok || out_q != exp_q) begin
      n_fail++; $display("FAIL rl_stream got %p want %p", out_q, exp_q);
    end
  endtask

  task automatic test_random();
    bit ok;
    reset_dut();
    gap_en = 1'b1;
    rdy_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N; k++) begin
        int nm;
        nm = (k == r % N) ? 1 + $urandom_range(1) : $urandom_range(2);
        for (int m = 0; m < nm; m++) push_msg(k, 1 + $urandom_range(3));
      end
      clear_logs();
      last_g = '0;
      predict();
      drain(2000, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL rand%0d_drain got not idle want idle within 2000", r); end
      n_chk++; if (out_q != exp_q) begin
        n_fail++; $display("FAIL rand%0d_stream got %0d beats want %0d", r, out_q.size(), exp_q.size());
      end
      n_chk++; if (gnt_q != exp_gnt) begin
        n_fail++; $display("FAIL rand%0d_order got %p want %p", r, gnt_q, exp_gnt);
      end
      n_chk++; if (n_to != 0) begin n_fail++; $display("FAIL rand%0d_timeout got %0d want 0", r, n_to); end
    end
  endtask

  // Continuous protocol checks: grant one-hot/zero, at most one ready,
  // quiet data when invalid, no owner change before tlast/timeout/reset.
  logic [N-1:0] mon_pg  = '0;
  bit           mon_rel = 1'b0;
  always @(negedge clk) begin
    n_chk++;
    if (!(gnt == '0 || $onehot(gnt))) begin n_fail++; $display("FAIL mon_onehot got %b want one-hot or 0", gnt); end
    n_chk++;
    if ($countones(req_ready) > 1) begin n_fail++; $display("FAIL mon_ready got %b want at most one", req_ready); end
    n_chk++;
    if (!m_valid && (m_data !== '0 || m_last !== 1'b0)) begin
      n_fail++; $display("FAIL mon_idle_data got d=%h l=%b want 0/0", m_data, m_last);
    end
    n_chk++;
    if (mon_pg != '0 && gnt != mon_pg && !mon_rel && !tmo && !rst) begin
      n_fail++; $display("FAIL mon_owner_switch got %b want %b", gnt, mon_pg);
    end
    mon_pg  = gnt;
    mon_rel = (m_valid && m_ready && m_last) || rst;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_reset_locked();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
